// File: rtl/mm_row_tiler.sv
// mm_row_tiler: buffers M_TILE matrix rows and replays them as M_TILE x N_TILE tiles for mm_adder.
// Define MM_ROW_TILER_PINGPONG_EN for two row banks so one band fills while the other drains.
module mm_row_tiler #(
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int M_TILE = 2,
    parameter int N_TILE = 2,
    parameter int DW_ADD = 32,
    parameter int DW_INT = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [DW_ADD*N-1:0]               in_row,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DW_ADD*M_TILE*N_TILE-1:0]   out,
    output logic                              out_valid,
    output logic [DW_INT-1:0]                 ptr_row,
    output logic [DW_INT-1:0]                 ptr_col,
    output logic                              out_done
);
    localparam int NT = N / N_TILE;
    localparam int BL = M / M_TILE - 1;
    localparam int RW = M_TILE > 1 ? $clog2(M_TILE) : 1;
    localparam int CW = $clog2(NT) + 1;
`ifdef MM_ROW_TILER_PINGPONG_EN
    localparam int NB = 2;
    logic       fb, db;
    logic [1:0] full;
`else
    localparam int NB = 1;
    localparam logic fb = 1'b0;
    localparam logic db = 1'b0;
    logic draining;
`endif
    logic [DW_ADD*N-1:0]             mem [NB][M_TILE];
    logic [DW_ADD*N-1:0]             sel;
    logic [DW_ADD*M_TILE*N_TILE-1:0] tile;
    logic [RW-1:0]                   row_cnt;
    logic [CW-1:0]                   col;
    logic [DW_INT-1:0]               band;
    logic accept, last_row, completing, emit, is_last, ov_q, done_q;

    assign accept     = in_valid & in_ready;
    assign last_row   = row_cnt == RW'(M_TILE - 1);
    assign completing = accept & last_row;
    assign is_last    = band == DW_INT'(BL) && col == CW'(NT - 1);
    assign out_valid  = ov_q & enable;
    assign out_done   = done_q & enable;
`ifdef MM_ROW_TILER_PINGPONG_EN
    assign in_ready = reset_n & enable & ~full[fb];
    assign emit     = full[db] | (completing & fb == db);
`else
    assign in_ready = reset_n & enable & ~draining;
    assign emit     = draining ? col != CW'(NT) : completing;
`endif

    // The row completing a band is still on in_row, so the first tile reads it directly.
    always_comb begin
        tile = '0;
        sel  = '0;
        for (int i = 0; i < M_TILE; i++) begin
            sel = (completing && fb == db && i == M_TILE - 1) ? in_row : mem[db][i];
            for (int j = 0; j < N_TILE; j++)
                tile[DW_ADD*(i*N_TILE+j) +: DW_ADD] = sel[DW_ADD*(int'(col)*N_TILE+j) +: DW_ADD];
        end
    end

    always_ff @(posedge clk)
        if (accept)
            mem[fb][row_cnt] <= in_row;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            out     <= '0;
            ptr_row <= '0;
            ptr_col <= '0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (enable) begin
            ov_q   <= emit;
            done_q <= emit & is_last;
            if (emit) begin
                out     <= tile;
                ptr_row <= band;
                ptr_col <= DW_INT'(col);
            end
        end

`ifdef MM_ROW_TILER_PINGPONG_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            row_cnt <= '0;
            col     <= '0;
            band    <= '0;
            fb      <= 1'b0;
            db      <= 1'b0;
            full    <= '0;
        end else if (enable) begin
            if (accept)
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            if (completing) begin
                full[fb] <= 1'b1;
                fb       <= ~fb;
            end
            if (emit) begin
                if (col == CW'(NT - 1)) begin
                    col      <= '0;
                    full[db] <= 1'b0;
                    db       <= ~db;
                    band     <= band == DW_INT'(BL) ? '0 : band + 1'b1;
                end else
                    col <= col + 1'b1;
            end
        end
`else
    // col reaching NT marks the trailing drain cycle that hands the buffer back to FILL.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            row_cnt  <= '0;
            col      <= '0;
            band     <= '0;
            draining <= 1'b0;
        end else if (enable) begin
            if (accept)
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            if (completing)
                draining <= 1'b1;
            if (emit)
                col <= col + 1'b1;
            else if (draining) begin
                draining <= 1'b0;
                col      <= '0;
                band     <= band == DW_INT'(BL) ? '0 : band + 1'b1;
            end
        end
`endif
endmodule
